// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks the memory one word at a time, runs each word through an
// external SEC-DED decoder, writes back corrected words and logs uncorrectable ones.
module ecc_scrub_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int INTERVAL = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr_cnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [38:0]       mem_wdata,
    input  logic [38:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [38:0]       dec_in,
    input  logic [38:0]       dec_out,
    input  logic              dec_sgl,
    input  logic              dec_dbl,
    output logic              busy,
    output logic [CNT_W-1:0]  sgl_cnt,
    output logic [CNT_W-1:0]  dbl_cnt,
    output logic [ADDR_W-1:0] dbl_addr,
    output logic              dbl_irq,
    output logic              pass_done
);

    localparam int                TMR_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD,
        CHK,
        WR,
        NEXT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [TMR_W-1:0]  timer;
    logic [38:0]       data;
    logic              xfer_done;
    logic              sgl_inc;
    logic              dbl_inc;

    assign dec_in    = data;
    assign xfer_done = mem_req && mem_ack;

    // A word flagged both single and double is treated as uncorrectable only.
    assign dbl_inc = (state == CHK) && dec_dbl;
    assign sgl_inc = (state == CHK) && !dec_dbl && dec_sgl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            timer     <= '0;
            data      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            sgl_cnt   <= '0;
            dbl_cnt   <= '0;
            dbl_addr  <= '0;
            dbl_irq   <= 1'b0;
            pass_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dbl_irq   <= 1'b0;
            pass_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (en) begin
                        timer <= TMR_LOAD;
                        busy  <= 1'b1;
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (timer == '0) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr;
                        state    <= RD;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                RD: begin
                    if (xfer_done) begin
                        data    <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= CHK;
                    end
                end

                CHK: begin
                    if (dec_dbl) begin
                        dbl_addr <= addr;
                        dbl_irq  <= 1'b1;
                        state    <= NEXT;
                    end else if (dec_sgl) begin
                        mem_wdata <= dec_out;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        state     <= WR;
                    end else begin
                        state <= NEXT;
                    end
                end

                WR: begin
                    if (xfer_done) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= NEXT;
                    end
                end

                NEXT: begin
                    if (addr == LAST_ADDR) begin
                        addr      <= '0;
                        pass_done <= 1'b1;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                    // Dropping en only takes effect here, so the address is kept for resume.
                    if (en) begin
                        timer <= TMR_LOAD;
                        state <= WAIT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase

            // Clear takes precedence over a same-cycle increment; counters stick at all-ones.
            if (clr_cnt) begin
                sgl_cnt <= '0;
                dbl_cnt <= '0;
            end else begin
                if (sgl_inc && sgl_cnt != CNT_MAX) begin
                    sgl_cnt <= sgl_cnt + CNT_W'(1);
                end
                if (dbl_inc && dbl_cnt != CNT_MAX) begin
                    dbl_cnt <= dbl_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: memory address width.
REQ-002 SHALL have parameter DEPTH, default 1024: words scrubbed per pass, 2..2^ADDR_W.
REQ-003 SHALL have parameter INTERVAL, default 16: idle cycles before each word, >=1.
REQ-004 SHALL have parameter CNT_W, default 16: error counter width.
REQ-005 SHALL have ports:
- CLK in 1: clock; one clock, all logic on its rising edge.
- RST in 1: reset, synchronous, active-high.
- EN in 1: scrub enable, level.
- CLR_CNT in 1: clear error counters, 1-cycle pulse.
- MEM_REQ out 1: memory request.
- MEM_WE out 1: 1 = write, 0 = read.
- MEM_ADDR out ADDR_W: word address.
- MEM_WDATA out 39: codeword to write.
- MEM_RDATA in 39: read codeword, valid when MEM_ACK=1 on a read.
- MEM_ACK in 1: memory accepts/completes the request.
- DEC_IN out 39: codeword to the SEC-DED decoder.
- DEC_OUT in 39: corrected codeword, combinational from DEC_IN.
- DEC_SGL in 1: single-bit error flag, combinational from DEC_IN.
- DEC_DBL in 1: double-bit error flag, combinational from DEC_IN.
- BUSY out 1: state is not IDLE.
- SGL_CNT out CNT_W: corrected-error count.
- DBL_CNT out CNT_W: uncorrectable-error count.
- DBL_ADDR out ADDR_W: address of the latest uncorrectable word.
- DBL_IRQ out 1: 1-cycle pulse per uncorrectable word.
- PASS_DONE out 1: 1-cycle pulse at the end of each full pass.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, RD, CHK, WR, NEXT; all outputs SHALL be registered except DEC_IN.
REQ-007 IDLE: EN=1 SHALL load timer with INTERVAL-1 and go to WAIT; EN=0 SHALL stay in IDLE.
REQ-008 WAIT: timer SHALL decrement each cycle; at timer=0 SHALL go to RD with MEM_REQ=1, MEM_WE=0, MEM_ADDR=current address.
REQ-009 Handshake: a transaction SHALL complete on the edge where MEM_REQ=1 and MEM_ACK=1; MEM_ADDR/MEM_WE/MEM_WDATA SHALL stay stable until then; MEM_REQ SHALL drop in the cycle after completion; MEM_ACK while MEM_REQ=0 SHALL be ignored.
REQ-010 RD: on completion SHALL capture MEM_RDATA into the data register and go to CHK.
REQ-011 DEC_IN SHALL continuously equal the data register.
REQ-012 CHK (one cycle), priority DBL over SGL:
- DEC_DBL=1: DBL_CNT+1, DBL_ADDR=address, DBL_IRQ=1 next cycle, go to NEXT (no writeback).
- else DEC_SGL=1: SGL_CNT+1, MEM_WDATA=DEC_OUT, go to WR with MEM_REQ=1, MEM_WE=1.
- else go to NEXT.
REQ-013 WR: on completion SHALL go to NEXT.
REQ-014 NEXT (one cycle):
- address = DEPTH-1: address wraps to 0, PASS_DONE=1 next cycle; otherwise address+1.
- EN=1: reload timer and go to WAIT; EN=0: go to IDLE.
REQ-015 Clean-word latency with immediate ACK SHALL be INTERVAL+3 cycles per word (WAIT INTERVAL, RD 1, CHK 1, NEXT 1); a corrected word SHALL add 1+ACK wait cycles.
REQ-016 EN deassertion outside IDLE SHALL NOT abort; the current word SHALL finish through NEXT, then IDLE; address SHALL be kept, and scrubbing SHALL resume there on the next EN.
REQ-017 Counters SHALL saturate at 2^CNT_W-1.
REQ-018 CLR_CNT SHALL zero SGL_CNT and DBL_CNT; CLR_CNT with a same-cycle increment SHALL leave 0 (clear wins); DBL_ADDR SHALL be unaffected.
REQ-019 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-020 RST=1 at any edge SHALL force IDLE with address=0, timer=0, data register=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, SGL_CNT=0, DBL_CNT=0, DBL_ADDR=0, DBL_IRQ=0, PASS_DONE=0, BUSY=0.
REQ-021 Reset during RD/WR SHALL drop MEM_REQ the next cycle with no completion and no counter change; RST SHALL have priority over all inputs.

Verification
REQ-022 Clean memory, DEPTH=4, INTERVAL=2, ACK immediate, EN=1 -> reads at addr 0,1,2,3, 5 cycles apart, no writes, PASS_DONE one pulse after addr 3, counters 0.
REQ-023 Word 2 has 1-bit flip (DEC_SGL=1) -> one write to addr 2 with MEM_WDATA=DEC_OUT, SGL_CNT=1, DBL_IRQ never asserted.
REQ-024 Word 1 has 2-bit flip (DEC_DBL=1) -> no write, DBL_CNT=1, DBL_ADDR=1, one DBL_IRQ pulse; DEC_SGL=DEC_DBL=1 together -> DBL path only.
REQ-025 MEM_ACK held off 5 cycles on read and write -> MEM_REQ/ADDR/WE/WDATA stable throughout; exactly one transaction each.
REQ-026 EN dropped in RD -> word completes, IDLE, BUSY=0; EN reasserted -> next read at address+1; CLR_CNT coincident with a CHK increment -> counter 0.
REQ-027 RST asserted in WR with ACK low -> next cycle MEM_REQ=0, all outputs at reset values; SGL_CNT forced to 2^CNT_W-1 (CNT_W=2) plus a further error -> stays 3.
